// File: rtl/camera_screen_projector_if.sv
// Shared types and handshake bundle for camera_screen_projector.
// Vertices are Q16.16 camera-space coordinates with a 24-bit color tag.
package camera_screen_projector_pkg;
  typedef logic signed [31:0] q16_16_t;

  typedef struct packed {
    q16_16_t     x;
    q16_16_t     y;
    q16_16_t     z;
    logic [23:0] color;
  } vertex_t;

  typedef vertex_t [2:0] triangle_t;
endpackage

interface camera_screen_projector_if;
  import camera_screen_projector_pkg::*;

  q16_16_t   focal;
  triangle_t triangle;
  logic      in_valid;
  logic      in_ready;
  triangle_t out_triangle;
  logic      out_valid;
  logic      out_ready;
  logic      busy;
  logic      culled;

  modport master (
    output focal, triangle, in_valid, out_ready,
    input  in_ready, out_triangle, out_valid, busy, culled
  );

  modport slave (
    input  focal, triangle, in_valid, out_ready,
    output in_ready, out_triangle, out_valid, busy, culled
  );
endinterface

// File: rtl/camera_screen_projector.sv
// Perspective projection of a camera-space triangle onto a SCREEN_W x SCREEN_H screen.
// Optional near-plane culling is enabled by defining NEAR_CULL_EN.
module camera_screen_projector
  import camera_screen_projector_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [31:0] NEAR_Z   = 32'h0000_1000
) (
  input  logic                      clk,
  input  logic                      rst,
  camera_screen_projector_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    MUL,
    DONE
`ifdef NEAR_CULL_EN
    , CULL
`endif
  } state_e;

  localparam q16_16_t              NEAR_Z_S = NEAR_Z;
  localparam logic signed [63:0]   CENTER_X = 64'(SCREEN_W / 2) << 16;
  localparam logic signed [63:0]   CENTER_Y = 64'(SCREEN_H / 2) << 16;

  state_e     state_q, state_d;
  logic [1:0] idx_q;
  logic [4:0] cnt_q;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  triangle_t  tri_q;
  q16_16_t    focal_q;
  triangle_t  out_tri_q;

  vertex_t    cur_v;
  q16_16_t    z_eff;
  logic       fit;
  logic       accept;

  logic signed [63:0] x64, y64, f64, r64;
  logic signed [63:0] xf, yf, xt, yt, xs, ys;

  function automatic q16_16_t sat(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)       return 32'h7FFF_FFFF;
    else if (v < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
    else                                    return v[31:0];
  endfunction

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
`ifdef NEAR_CULL_EN
  logic any_near;
  always_comb begin
    any_near = 1'b0;
    for (int unsigned i = 0; i < 3; i++)
      if (bus.triangle[i].z < NEAR_Z_S) any_near = 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
`ifdef NEAR_CULL_EN
        state_d = any_near ? CULL : DIV;
`else
        state_d = DIV;
`endif
      end
      DIV:  if (cnt_q == 5'd31) state_d = MUL;
      MUL:  state_d = (idx_q == 2'd2) ? DONE : DIV;
      DONE: if (bus.out_ready) state_d = IDLE;
`ifdef NEAR_CULL_EN
      CULL: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.in_ready     = (state_q == IDLE);
    bus.busy         = (state_q != IDLE);
    bus.out_valid    = (state_q == DONE);
    bus.out_triangle = out_tri_q;
`ifdef NEAR_CULL_EN
    bus.culled       = (state_q == CULL);
`else
    bus.culled       = 1'b0;
`endif
  end

  // ---------------- datapath ----------------
  assign accept = (state_q == IDLE) && bus.in_valid;

  // Remainder stays below z_eff < 2^31, so its shifted-out MSB alone proves the fit.
  always_comb begin
    cur_v = tri_q[idx_q];
    z_eff = (cur_v.z < NEAR_Z_S) ? NEAR_Z_S : cur_v.z;
    fit   = rem_q[31] || ({rem_q[30:0], 1'b0} >= z_eff);
    rem_d = fit ? ({rem_q[30:0], 1'b0} - z_eff) : {rem_q[30:0], 1'b0};
    quo_d = {quo_q[30:0], fit};
  end

  always_comb begin
    x64 = cur_v.x;
    y64 = cur_v.y;
    f64 = focal_q;
    r64 = {32'h0, quo_q};
    xf  = (x64 * f64) >>> 16;
    yf  = (y64 * f64) >>> 16;
    xt  = (xf * r64) >>> 16;
    yt  = (yf * r64) >>> 16;
    xs  = CENTER_X + xt;
    ys  = CENTER_Y - yt;
  end

  // The 2^32 dividend's top bit is pre-loaded as remainder 1, leaving 32 iterations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      tri_q     <= '0;
      focal_q   <= '0;
      out_tri_q <= '0;
    end else begin
      if (accept) begin
        tri_q   <= bus.triangle;
        focal_q <= bus.focal;
        idx_q   <= '0;
        cnt_q   <= '0;
        rem_q   <= 32'd1;
        quo_q   <= '0;
      end else if (state_q == DIV) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == MUL) begin
        out_tri_q[idx_q] <= '{x: sat(xs), y: sat(ys), z: cur_v.z, color: cur_v.color};
        if (idx_q != 2'd2) idx_q <= idx_q + 2'd1;
        cnt_q <= '0;
        rem_q <= 32'd1;
        quo_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_camera_screen_projector.sv
// Directed bench for camera_screen_projector with hand-computed projections.
module tb_camera_screen_projector;
  import camera_screen_projector_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  camera_screen_projector_if bus();

  camera_screen_projector #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .NEAR_Z   (32'h0000_1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vertex_t mkv(input q16_16_t px, input q16_16_t py,
                                  input q16_16_t pz, input logic [23:0] pc);
    return '{x: px, y: py, z: pz, color: pc};
  endfunction

  task automatic cmp_tri(input string tag, input triangle_t exp);
    triangle_t got;
    got = bus.out_triangle;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.v%0d.x", tag, i), 64'(got[i].x), 64'(exp[i].x));
      check($sformatf("%s.v%0d.y", tag, i), 64'(got[i].y), 64'(exp[i].y));
      check($sformatf("%s.v%0d.z", tag, i), 64'(got[i].z), 64'(exp[i].z));
      check($sformatf("%s.v%0d.c", tag, i), 64'(got[i].color), 64'(exp[i].color));
    end
  endtask

  task automatic accept_tri(input string tag, input triangle_t t, input q16_16_t f);
    @(negedge clk);
    check({tag, ".in_ready_pre"}, 64'(bus.in_ready), 64'd1);
    bus.triangle = t;
    bus.focal    = f;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.triangle = '1;
    bus.focal    = 32'h1234_5678;
  endtask

  task automatic project(input string tag, input triangle_t t, input q16_16_t f,
                         input triangle_t exp, input int hold);
    int n;
    bus.out_ready = (hold == 0);
    accept_tri(tag, t, f);
    check({tag, ".busy"}, 64'(bus.busy), 64'd1);
    check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd99);
    cmp_tri(tag, exp);
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      cmp_tri({tag, ".held"}, exp);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ".valid_after"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
    check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  triangle_t ta, ea, tb_, eb, tc, ec, td, ed;

  initial begin
    // (1,1,2) (-2,0.5,1) (3,-4,4), focal 1.0
    ta[0] = mkv(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 24'h112233);
    ta[1] = mkv(32'hFFFE_0000, 32'h0000_8000, 32'h0001_0000, 24'h445566);
    ta[2] = mkv(32'h0003_0000, 32'hFFFC_0000, 32'h0004_0000, 24'h778899);
    ea[0] = mkv(32'h0050_8000, 32'h003B_8000, 32'h0002_0000, 24'h112233);
    ea[1] = mkv(32'h004E_0000, 32'h003B_8000, 32'h0001_0000, 24'h445566);
    ea[2] = mkv(32'h0050_C000, 32'h003D_0000, 32'h0004_0000, 24'h778899);
    // focal 2.0, z=3 gives r=0x5555 (truncated), plus a tiny negative x
    tb_[0] = mkv(32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 24'hAAAAAA);
    tb_[1] = mkv(32'h0001_0000, 32'hFFFF_0000, 32'h0003_0000, 24'hBBBBBB);
    tb_[2] = mkv(32'hFFFF_FFFF, 32'h0000_0000, 32'h0001_0000, 24'hCCCCCC);
    eb[0]  = mkv(32'h0050_AAAA, 32'h003B_5556, 32'h0003_0000, 24'hAAAAAA);
    eb[1]  = mkv(32'h0050_AAAA, 32'h003C_AAAA, 32'h0003_0000, 24'hBBBBBB);
    eb[2]  = mkv(32'h004F_FFFE, 32'h003C_0000, 32'h0001_0000, 24'hCCCCCC);
    // saturation in both directions
    tc[0] = mkv(32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_1000, 24'h010203);
    tc[1] = mkv(32'h8001_0000, 32'h8001_0000, 32'h0000_1000, 24'h040506);
    tc[2] = mkv(32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_1000, 24'h070809);
    ec[0] = mkv(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1000, 24'h010203);
    ec[1] = mkv(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_1000, 24'h040506);
    ec[2] = mkv(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1000, 24'h070809);
    // z = -1.0, 0, NEAR_Z all clamp to NEAR_Z -> r = 2^20
    td[0] = mkv(32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000, 24'hDEAD01);
    td[1] = mkv(32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 24'hDEAD02);
    td[2] = mkv(32'h0001_0000, 32'h0000_0000, 32'h0000_1000, 24'hDEAD03);
    ed[0] = mkv(32'h0060_0000, 32'h003C_0000, 32'hFFFF_0000, 24'hDEAD01);
    ed[1] = mkv(32'h0060_0000, 32'h003C_0000, 32'h0000_0000, 24'hDEAD02);
    ed[2] = mkv(32'h0060_0000, 32'h003C_0000, 32'h0000_1000, 24'hDEAD03);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.triangle  = '0;
    bus.focal     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.culled", 64'(bus.culled), 64'd0);
    check("rst.out_tri_zero", 64'(|bus.out_triangle), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    project("basic", ta, 32'h0001_0000, ea, 0);
    project("hold", tb_, 32'h0002_0000, eb, 20);
    project("sat", tc, 32'h0010_0000, ec, 0);

`ifdef NEAR_CULL_EN
    begin
      int hits;
      accept_tri("cull", td, 32'h0001_0000);
      check("cull.pulse", 64'(bus.culled), 64'd1);
      check("cull.no_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("cull.pulse_end", 64'(bus.culled), 64'd0);
      check("cull.in_ready", 64'(bus.in_ready), 64'd1);
      hits = 0;
      repeat (110) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) hits++;
      end
      check("cull.never_valid", 64'(hits), 64'd0);
    end
`else
    project("near", td, 32'h0001_0000, ed, 0);
`endif

    // abort mid-flight with reset, then confirm a clean projection afterwards
    accept_tri("abort", ta, 32'h0001_0000);
    repeat (49) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort.out_valid", 64'(bus.out_valid), 64'd0);
    check("abort.in_ready", 64'(bus.in_ready), 64'd1);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.out_tri_zero", 64'(|bus.out_triangle), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    project("after_rst", ta, 32'h0001_0000, ea, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
